// File: rtl/ir_frame_ctrl.sv
// rtl/ir_frame_ctrl.sv - IR receiver front end: line sync, width measurement, frame FSM, code latch
// Optional repeat-frame support is enabled by defining IR_REPEAT_EN.
module ir_frame_ctrl #(
  parameter int TICK_DIV       = 5000,
  parameter int LEAD_MARK_MIN  = 160,
  parameter int LEAD_SPACE_MIN = 70,
`ifdef IR_REPEAT_EN
  parameter int REP_SPACE_MIN  = 30,
`endif
  parameter int BIT_ONE_MIN    = 22,
  parameter int TIMEOUT        = 200
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ir_rx,
  output logic [15:0] code,
  output logic        latch,
  output logic        frame_err,
  output logic        busy,
  output logic        repeat_hit
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_MARK,
    S_LEAD_SPACE,
    S_BIT_MARK,
    S_BIT_SPACE,
    S_DONE
`ifdef IR_REPEAT_EN
    , S_REPEAT
`endif
  } state_t;

  state_t        state_q, state_d;
  logic          rx_s1_q, rx_s2_q, rx_s3_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    width_q, width_d;
  logic [4:0]    bitcnt_q, bitcnt_d;
  logic [15:0]   shift_q, shift_d;
  logic [15:0]   code_q, code_d;
  logic          pend_q;
  logic          latch_q;
  logic          frame_err_q;
  logic          err_d;
  logic          tick, fall, rise, timeout;

  assign tick    = (presc_q == PW'(TICK_DIV - 1));
  assign presc_d = tick ? '0 : presc_q + 1'b1;
  assign fall    = rx_s3_q & ~rx_s2_q;
  assign rise    = ~rx_s3_q & rx_s2_q;
  assign timeout = (width_q >= 8'(TIMEOUT));

  // Edge clears the width even when a tick lands in the same cycle.
  always_comb begin
    width_d = width_q;
    if (fall || rise) begin
      width_d = 8'd0;
    end else if (tick && (width_q != 8'hFF)) begin
      width_d = width_q + 8'd1;
    end
  end

`ifdef IR_REPEAT_EN
  logic rep_d;
  logic repeat_hit_q;
  logic have_code_q;
`endif

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    code_d   = code_q;
    err_d    = 1'b0;
`ifdef IR_REPEAT_EN
    rep_d    = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d  = S_LEAD_MARK;
          shift_d  = 16'h0000;
          bitcnt_d = 5'd0;
        end
      end
      S_LEAD_MARK: begin
        if (rise) begin
          if (width_q >= 8'(LEAD_MARK_MIN)) begin
            state_d = S_LEAD_SPACE;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_LEAD_SPACE: begin
        if (fall) begin
          if (width_q >= 8'(LEAD_SPACE_MIN)) begin
            state_d  = S_BIT_MARK;
            bitcnt_d = 5'd0;
`ifdef IR_REPEAT_EN
          end else if (width_q >= 8'(REP_SPACE_MIN)) begin
            state_d = S_REPEAT;
`endif
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_BIT_MARK: begin
        if (rise) begin
          state_d = S_BIT_SPACE;
        end
      end
      S_BIT_SPACE: begin
        if (fall) begin
          shift_d  = {shift_q[14:0], (width_q >= 8'(BIT_ONE_MIN))};
          bitcnt_d = bitcnt_q + 5'd1;
          state_d  = (bitcnt_q == 5'd15) ? S_DONE : S_BIT_MARK;
        end
      end
      S_DONE: begin
        code_d  = shift_q;
        state_d = S_IDLE;
      end
`ifdef IR_REPEAT_EN
      S_REPEAT: begin
        if (rise) begin
          rep_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A level that outlasts TIMEOUT aborts the frame regardless of any edge this cycle.
    if ((state_q != S_IDLE) && (state_q != S_DONE) && timeout) begin
      err_d   = 1'b1;
      state_d = S_IDLE;
`ifdef IR_REPEAT_EN
      rep_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_s3_q     <= 1'b1;
      presc_q     <= '0;
      width_q     <= 8'd0;
      bitcnt_q    <= 5'd0;
      shift_q     <= 16'h0000;
      code_q      <= 16'h0000;
      pend_q      <= 1'b0;
      latch_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_s1_q     <= ir_rx;
      rx_s2_q     <= rx_s1_q;
      rx_s3_q     <= rx_s2_q;
      presc_q     <= presc_d;
      width_q     <= width_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      code_q      <= code_d;
      pend_q      <= (state_q == S_DONE);
      frame_err_q <= err_d;
`ifdef IR_REPEAT_EN
      latch_q     <= pend_q | (rep_d & have_code_q);
`else
      latch_q     <= pend_q;
`endif
    end
  end

`ifdef IR_REPEAT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      repeat_hit_q <= 1'b0;
      have_code_q  <= 1'b0;
    end else begin
      repeat_hit_q <= rep_d;
      if (state_q == S_DONE) begin
        have_code_q <= 1'b1;
      end
    end
  end
  assign repeat_hit = repeat_hit_q;
`else
  assign repeat_hit = 1'b0;
`endif

  assign code      = code_q;
  assign latch     = latch_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_ir_frame_ctrl.sv
// tb/tb_ir_frame_ctrl.sv - scoreboard bench for ir_frame_ctrl with directed IR frames
module tb_ir_frame_ctrl;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ir_rx = 1'b1;
  logic [15:0] code;
  logic        latch, frame_err, busy, repeat_hit;

  typedef struct {
    int          kind;
    logic [15:0] code;
  } ev_t;

  ev_t         exp_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  logic [15:0] prev_code = 16'h0000;

  ir_frame_ctrl #(.TICK_DIV(TD)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ir_rx     (ir_rx),
    .code      (code),
    .latch     (latch),
    .frame_err (frame_err),
    .busy      (busy),
    .repeat_hit(repeat_hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [15:0] c);
    ev_t e;
    e.kind = kind;
    e.code = c;
    exp_q.push_back(e);
  endtask

  task automatic lvl(input logic v, input int ticks);
    ir_rx = v;
    repeat (ticks * TD) @(negedge clk);
  endtask

  task automatic lead();
    lvl(1'b0, 180);
    lvl(1'b1, 90);
  endtask

  task automatic bits(input logic [15:0] c, input int n);
    for (int i = 15; i > 15 - n; i--) begin
      lvl(1'b0, 11);
      lvl(1'b1, c[i] ? 34 : 11);
    end
  endtask

  task automatic send_frame(input logic [15:0] c);
    push(0, c);
    lead();
    bits(c, 16);
    lvl(1'b0, 11);
    lvl(1'b1, 20);
  endtask

  // Monitor: kind 0 = latch, 1 = frame_err, 2 = repeat_hit with latch
  always @(negedge clk) begin
    if (latch || frame_err || repeat_hit) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {29'd0, repeat_hit, frame_err, latch}, 32'd0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        case (e.kind)
          0: begin
            chk("latch_evt", {29'd0, repeat_hit, frame_err, latch}, 32'b001);
            chk("latch_code", {16'd0, code}, {16'd0, e.code});
            chk("code_before_latch", {16'd0, prev_code}, {16'd0, e.code});
          end
          1: chk("err_evt", {29'd0, repeat_hit, frame_err, latch}, 32'b010);
          default: begin
            chk("repeat_evt", {29'd0, repeat_hit, frame_err, latch}, 32'b101);
            chk("repeat_code", {16'd0, code}, {16'd0, e.code});
          end
        endcase
      end
    end
    prev_code <= code;
  end

  initial begin
    reset_n = 1'b0;
    ir_rx   = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_code", {16'd0, code}, 32'h0);
    chk("rst_latch", {31'd0, latch}, 32'd0);
    chk("rst_err", {31'd0, frame_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rep", {31'd0, repeat_hit}, 32'd0);
    reset_n = 1'b1;
    lvl(1'b1, 10);

    send_frame(16'h0A0B);
    chk("t1_code", {16'd0, code}, 32'h0A0B);

    push(1, 16'h0);
    lvl(1'b0, 100);
    lvl(1'b1, 90);
    chk("t2_code_kept", {16'd0, code}, 32'h0A0B);
    chk("t2_busy", {31'd0, busy}, 32'd0);

    push(1, 16'h0);
    lead();
    bits(16'h0A04, 8);
    chk("t3_busy_mid", {31'd0, busy}, 32'd1);
    lvl(1'b1, 220);
    chk("t3_busy_after_to", {31'd0, busy}, 32'd0);
    chk("t3_code_kept", {16'd0, code}, 32'h0A0B);
    send_frame(16'h0A04);
    chk("t3_code", {16'd0, code}, 32'h0A04);

    lead();
    bits(16'h0A06, 10);
    ir_rx = 1'b1;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("t4_code", {16'd0, code}, 32'h0);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_latch", {31'd0, latch}, 32'd0);
    chk("t4_err", {31'd0, frame_err}, 32'd0);
    chk("t4_rep", {31'd0, repeat_hit}, 32'd0);
    lvl(1'b1, 20);
    send_frame(16'h0A12);
    chk("t4_code_after", {16'd0, code}, 32'h0A12);

    send_frame(16'h0A06);
`ifdef IR_REPEAT_EN
    push(2, 16'h0A06);
`else
    push(1, 16'h0);
`endif
    lvl(1'b0, 180);
    lvl(1'b1, 45);
    lvl(1'b0, 11);
    lvl(1'b1, 20);
    chk("t5_code", {16'd0, code}, 32'h0A06);

    send_frame(16'h0A08);
    for (int k = 0; k < 4; k++) begin
      lvl(1'b1, 195);
      chk("t6_gap_busy", {31'd0, busy}, 32'd0);
    end
    send_frame(16'h0A10);
    chk("t6_code", {16'd0, code}, 32'h0A10);

    lvl(1'b1, 50);
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
